// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    MERGE,
    RESP
  } state_e;

  // Little-endian lanes: lane 0 is bits [7:0].
  function automatic logic [DATA_W-1:0] merge_byte(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        data_byte);
    logic [DATA_W-1:0] merged;
    merged = word;
    merged[lane*8 +: 8] = data_byte;
    return merged;
  endfunction

  function automatic logic [DATA_W-1:0] load_byte_sext(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        lane);
    logic [7:0] lane_byte;
    lane_byte = word[lane*8 +: 8];
    return {{(DATA_W-8){lane_byte[7]}}, lane_byte};
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous word RAM: write on the edge, registered read (read-first).
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Target side of the MEM-stage load/store interface: one request in flight, programmable wait.
// IDLE accept | WAIT wait states | ACCESS RAM read/write | MERGE byte RMW write | RESP hold response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic              i_req_byte,
  input  logic [31:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e            state_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              we_q;
  logic              byte_q;
  logic              err_q;
  logic [ADDR_W+1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;

  logic              req_fire;
  logic              req_err_d;
  logic              sram_we;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic [DATA_W-1:0] merged_d;
  logic [DATA_W-1:0] load_data_d;

  assign req_fire  = i_req_valid & ready_q;
  assign req_err_d = (!i_req_byte && (i_req_addr[1:0] != 2'b00)) ||
                     ((i_req_addr >> (ADDR_W + 2)) != 32'd0);

  // The RAM read issued in ACCESS is still on sram_rdata during MERGE.
  assign merged_d    = merge_byte(sram_rdata, addr_q[1:0], wdata_q[7:0]);
  assign load_data_d = byte_q ? load_byte_sext(sram_rdata, addr_q[1:0]) : sram_rdata;

  assign sram_we    = !rst && (((state_q == ACCESS) && we_q && !byte_q) || (state_q == MERGE));
  assign sram_wdata = (state_q == MERGE) ? merged_d : wdata_q;

  dmem_sram #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .addr (addr_q[ADDR_W+1:2]),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      byte_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            ready_q <= 1'b0;
            we_q    <= i_req_we;
            byte_q  <= i_req_byte;
            err_q   <= req_err_d;
            addr_q  <= i_req_addr[ADDR_W+1:0];
            wdata_q <= i_req_wdata;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= WAIT_LOAD;
            end else if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (err_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACCESS: begin
          if (we_q && byte_q) begin
            state_q <= MERGE;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
          end
        end
        MERGE: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
        end
        RESP: begin
          if (i_resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          ready_q      <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = ready_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_err   = resp_err_q;
  // Address and RAM are frozen in RESP, so the formatted read data stays stable.
  assign o_resp_rdata = (resp_valid_q && !resp_err_q && !we_q) ? load_data_d : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=10, WAIT_CYCLES=2) with hand-computed expectations.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic        i_req_byte;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .ADDR_W     (10),
    .WAIT_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_byte  (i_req_byte),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata),
    .o_resp_err  (o_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Latency k = number of negedges after the accept edge
  // up to and including the first one that sees o_resp_valid high.
  task automatic do_req(input logic we, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output int lat, output logic [31:0] rd, output logic er);
    int k;
    k = 0;
    while (!o_req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_idle", o_req_ready, 1'b1);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_byte  = bt;
    i_req_addr  = addr;
    i_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_we    = ~we;
    i_req_byte  = ~bt;
    i_req_addr  = 32'hFFFF_FFFF;
    i_req_wdata = 32'h5A5A_5A5A;
    k   = 1;
    lat = -1;
    while (!o_resp_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (o_resp_valid) lat = k;
    check("resp_timeout", o_resp_valid, 1'b1);
    rd = o_resp_rdata;
    er = o_resp_err;
    check("req_ready_busy", o_req_ready, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", o_resp_valid, 1'b1);
      check("hold_rdata", o_resp_rdata, rd);
      check("hold_err", o_resp_err, er);
      check("hold_req_ready", o_req_ready, 1'b0);
    end
    i_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_resp_ready = 1'b0;
    check("resp_done", o_resp_valid, 1'b0);
    check("req_ready_after", o_req_ready, 1'b1);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst          = 1'b1;
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_byte   = 1'b0;
    i_req_addr   = 32'h0000_0010;
    i_req_wdata  = 32'h1234_5678;
    i_resp_ready = 1'b0;

    // 1: reset values and release
    repeat (3) @(negedge clk);
    check("rst_ready", o_req_ready, 1'b0);
    check("rst_valid", o_resp_valid, 1'b0);
    check("rst_rdata", o_resp_rdata, 32'h0);
    check("rst_err", o_resp_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", o_req_ready, 1'b1);
    i_req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rel_no_accept_valid", o_resp_valid, 1'b0);
    check("rel_no_accept_ready", o_req_ready, 1'b1);

    // 2: word store then word load
    do_req(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0, lat, rd, er);
    check("wst_lat", lat, 4);
    check("wst_err", er, 1'b0);
    check("wst_rdata", rd, 32'h0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er);
    check("wld_lat", lat, 4);
    check("wld_rdata", rd, 32'hDEAD_BEEF);
    check("wld_err", er, 1'b0);

    // 3: byte store read-modify-write and byte loads
    do_req(1'b1, 1'b1, 32'h0000_0011, 32'hAAAA_AA7F, 0, lat, rd, er);
    check("bst_lat", lat, 5);
    check("bst_err", er, 1'b0);
    check("bst_rdata", rd, 32'h0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er);
    check("bst_readback", rd, 32'hDEAD_7FEF);
    do_req(1'b0, 1'b1, 32'h0000_0013, 32'h0, 0, lat, rd, er);
    check("bld3_lat", lat, 4);
    check("bld3_rdata", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 1'b1, 32'h0000_0012, 32'h0, 0, lat, rd, er);
    check("bld2_rdata", rd, 32'hFFFF_FFAD);
    do_req(1'b0, 1'b1, 32'h0000_0011, 32'h0, 0, lat, rd, er);
    check("bld1_rdata", rd, 32'h0000_007F);

    // 4: errors
    do_req(1'b0, 1'b0, 32'h0000_0012, 32'h0, 0, lat, rd, er);
    check("mis_lat", lat, 3);
    check("mis_err", er, 1'b1);
    check("mis_rdata", rd, 32'h0);
    do_req(1'b1, 1'b0, 32'h0000_0000, 32'h0102_0304, 0, lat, rd, er);
    check("w0_err", er, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 0, lat, rd, er);
    check("oor_lat", lat, 3);
    check("oor_err", er, 1'b1);
    do_req(1'b1, 1'b0, 32'h0000_0012, 32'hCAFE_F00D, 0, lat, rd, er);
    check("mis_st_err", er, 1'b1);
    do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 0, lat, rd, er);
    check("oor_ram_unchanged", rd, 32'h0102_0304);
    check("oor_ram_err", er, 1'b0);
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er);
    check("mis_ram_unchanged", rd, 32'hDEAD_7FEF);

    // 5: backpressure
    do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 6, lat, rd, er);
    check("bp_rdata", rd, 32'hDEAD_7FEF);
    check("bp_lat", lat, 4);

    // 6: reset during MERGE of a byte store
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 0, lat, rd, er);
    check("pre_rst_err", er, 1'b0);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_byte  = 1'b1;
    i_req_addr  = 32'h0000_0020;
    i_req_wdata = 32'h0000_0099;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_valid", o_resp_valid, 1'b0);
    check("mrst_ready", o_req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_rel", o_req_ready, 1'b1);
    do_req(1'b0, 1'b0, 32'h0000_0020, 32'h0, 0, lat, rd, er);
    check("mrst_ram", rd, 32'h1122_3344);
    check("mrst_lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
